// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative 64-step shift-add multiply / restoring divide sequencer.
// Optional word ops (MULW/DIVW/DIVUW/REMW/REMUW) enabled by defining MULDIV_WORD_EN.
module muldiv_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] c
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [63:0] acc, x, y, c_r;
  logic        word_r, div_r, rem_r, neg_q, neg_r;

  function automatic logic [63:0] wfix(input logic [63:0] v, input logic w);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  logic        in_word, in_div, in_rem, in_sgn, in_sx, supported;
  logic [63:0] a_ext, b_ext, a_abs, b_abs, spec_res;
  logic        a_neg, b_neg, dz, ovf;

`ifdef MULDIV_WORD_EN
  assign in_word = op[3];
`else
  assign in_word = 1'b0;
`endif

  assign supported = (op[2:0] <= 3'd4) && (!op[3] || in_word);
  assign in_div    = (op[2:0] != 3'd0);
  assign in_rem    = (op[2:0] == 3'd3) || (op[2:0] == 3'd4);
  assign in_sgn    = (op[2:0] == 3'd1) || (op[2:0] == 3'd3);
  assign in_sx     = (op[2:0] != 3'd2) && (op[2:0] != 3'd4);
  assign a_ext     = !in_word ? a : (in_sx ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]});
  assign b_ext     = !in_word ? b : (in_sx ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]});
  assign a_neg     = in_sgn & a_ext[63];
  assign b_neg     = in_sgn & b_ext[63];
  assign a_abs     = a_neg ? -a_ext : a_ext;
  assign b_abs     = b_neg ? -b_ext : b_ext;
  assign dz        = in_div && (b_ext == 64'd0);
  assign ovf       = in_sgn && (in_word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                                        : (a == 64'h8000_0000_0000_0000 && b == '1));
  assign spec_res  = dz ? (in_rem ? a_ext : '1) : (in_rem ? 64'd0 : a_ext);

  // Shared adder: multiply adds the gated multiplicand, divide subtracts the divisor
  // from the shifted partial remainder (always fits 65-bit signed since rem < divisor).
  logic [64:0] add_a, add_b, add_sum;
  logic        div_ok;
  logic [63:0] acc_nx, x_nx, y_nx, res;

  always_comb begin
    add_a = div_r ? {acc, x[63]} : {1'b0, acc};
    add_b = div_r ? ~{1'b0, y} : {1'b0, (x[0] ? y : 64'd0)};
    add_sum = add_a + add_b + {64'd0, div_r};
    div_ok = ~add_sum[64];
    if (div_r) begin
      acc_nx = div_ok ? add_sum[63:0] : add_a[63:0];
      x_nx   = {x[62:0], div_ok};
      y_nx   = y;
    end else begin
      acc_nx = add_sum[63:0];
      x_nx   = {1'b0, x[63:1]};
      y_nx   = {y[62:0], 1'b0};
    end
    if (!div_r)     res = acc_nx;
    else if (rem_r) res = neg_r ? -acc_nx : acc_nx;
    else            res = neg_q ? -x_nx : x_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid && !flush) state_nx = (supported && !dz && !ovf) ? BUSY : DONE;
      BUSY: if (flush) state_nx = IDLE; else if (cnt == 6'd0) state_nx = DONE;
      DONE: if (flush || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      acc    <= 64'd0;
      x      <= 64'd0;
      y      <= 64'd0;
      c_r    <= 64'd0;
      word_r <= 1'b0;
      div_r  <= 1'b0;
      rem_r  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid && !flush) begin
          word_r <= in_word;
          div_r  <= in_div;
          rem_r  <= in_rem;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          cnt    <= 6'd63;
          acc    <= 64'd0;
          x      <= in_div ? a_abs : b_ext;
          y      <= in_div ? b_abs : a_ext;
          if (!supported)     c_r <= 64'd0;
          else if (dz || ovf) c_r <= wfix(spec_res, in_word);
        end
        BUSY: if (!flush) begin
          acc <= acc_nx;
          x   <= x_nx;
          y   <= y_nx;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd0) c_r <= wfix(res, word_r);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign c         = c_r;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq (word ops follow MULDIV_WORD_EN).
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [63:0] a = 64'd0;
  logic [63:0] b = 64'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] c;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  muldiv_seq #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .c(c)
  );

  always #5 clk = ~clk;

  // Drive one request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [63:0] aa, input logic [63:0] bb,
                       input logic [63:0] exp_c);
    op = o; a = aa; b = bb; in_valid = 1'b1;
    exp_q.push_back(exp_c);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 64'hDEAD_BEEF_0BAD_F00D; b = 64'h1234_5678_9ABC_DEF0;
  endtask

  task automatic collect(input string name, input int exp_lat);
    int lat;
    int rdy_hi;
    logic [63:0] exp_c;
    lat = 1; rdy_hi = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) rdy_hi++;
      @(negedge clk);
      lat++;
    end
    if (in_ready !== 1'b0) rdy_hi++;
    exp_c = exp_q.pop_front();
    tests++;
    if (lat != exp_lat) begin
      fails++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    tests++;
    if (c !== exp_c) begin
      fails++; $display("FAIL %s result: got %h expected %h", name, c, exp_c);
    end
    tests++;
    if (rdy_hi != 0) begin
      fails++; $display("FAIL %s in_ready_low: high on %0d cycles expected 0", name, rdy_hi);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL %s release: in_ready=%b out_valid=%b expected 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 64'd0) begin
      fails++; $display("FAIL reset_state: in_ready=%b out_valid=%b c=%h expected 1/0/0", in_ready, out_valid, c);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul;
    issue(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    collect("mul_7_neg3", 65);
    issue(4'd0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001);
    collect("mul_wide", 65);
  endtask

  task automatic test_div;
    issue(4'd1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    collect("div_neg7_2", 65);
    issue(4'd3, -64'sd7, 64'd2, ONES);
    collect("rem_neg7_2", 65);
    issue(4'd2, 64'd100, 64'd7, 64'd14);
    collect("divu_100_7", 65);
    issue(4'd4, 64'd100, 64'd7, 64'd2);
    collect("remu_100_7", 65);
    issue(4'd2, ONES, 64'd3, 64'h5555_5555_5555_5555);
    collect("divu_big", 65);
  endtask

  task automatic test_special;
    issue(4'd2, 64'd5, 64'd0, ONES);
    collect("divu_by_zero", 1);
    issue(4'd3, 64'd5, 64'd0, 64'd5);
    collect("rem_by_zero", 1);
    issue(4'd1, MINV, ONES, MINV);
    collect("div_overflow", 1);
    issue(4'd3, MINV, ONES, 64'd0);
    collect("rem_overflow", 1);
    issue(4'd5, 64'd9, 64'd9, 64'd0);
    collect("unsupported_op5", 1);
  endtask

  task automatic test_hold;
    int n;
    issue(4'd2, 64'd100, 64'd7, 64'd14);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      op = 4'd0; a = 64'd2; b = 64'd2; in_valid = 1'b1;
      @(negedge clk);
      tests++;
      if (c !== exp_q[0] || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++; $display("FAIL hold_%0d: c=%h out_valid=%b in_ready=%b expected %h/1/0", i, c, out_valid, in_ready, exp_q[0]);
      end
    end
    in_valid = 1'b0;
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL hold_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush;
    int seen;
    issue(4'd0, 64'd11, 64'd13, 64'd143);
    seen = 0;
    for (int i = 1; i < 30; i++) begin
      if (out_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(exp_q.pop_front());
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || seen != 0) begin
      fails++; $display("FAIL flush_busy: in_ready=%b out_valid=%b early_valid=%0d expected 1/0/0", in_ready, out_valid, seen);
    end
    flush = 1'b1; op = 4'd0; a = 64'd1; b = 64'd1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_idle_block: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    issue(4'd0, 64'd3, 64'd4, 64'd12);
    collect("mul_after_flush", 65);
    issue(4'd2, 64'd7, 64'd0, ONES);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    void'(exp_q.pop_front());
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_done: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    issue(4'd1, 64'd1000, 64'd3, 64'd333);
    for (int i = 0; i < 20; i++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 64'd0) begin
      fails++; $display("FAIL reset_mid: in_ready=%b out_valid=%b c=%h expected 1/0/0", in_ready, out_valid, c);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(4'd0, 64'd3, 64'd4, 64'd12);
    collect("mul_after_reset", 65);
  endtask

  task automatic test_word;
`ifdef MULDIV_WORD_EN
    issue(4'd9, 64'h1_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    collect("divw", 65);
    issue(4'd8, 64'h10000, 64'h10000, 64'd0);
    collect("mulw", 65);
    issue(4'd8, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    collect("mulw_neg", 65);
    issue(4'd9, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    collect("divw_overflow", 1);
    issue(4'd12, 64'h9_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001);
    collect("remuw_by_zero", 1);
`else
    issue(4'd9, 64'h1_FFFF_FFF9, 64'd2, 64'd0);
    collect("divw_unsupported", 1);
    issue(4'd8, 64'h10000, 64'h10000, 64'd0);
    collect("mulw_unsupported", 1);
`endif
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_hold();
    test_flush();
    test_reset_mid();
    test_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the execute stage. It accepts one M-extension operation through a valid/ready handshake and runs a 64-step shift-add multiply or restoring divide over a single shared adder/subtractor. It holds the 64-bit result until the pipeline accepts it. The execute stage stalls on `in_ready`/`out_valid`; the ALU continues to handle all single-cycle ops.

## Interface
- `XLEN`, 64, operand/result width; only 64 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  sequencer can accept (high only in IDLE).
- `op`  in  4  operation: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW.
- `a`, `b`  in  64 each  operands (u64); `a` is the multiplicand/dividend.
- `flush`  in  1  abort the in-flight operation (pipeline redirect).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `c`  out  64  result (u64).

## Operation
- States are IDLE, BUSY and DONE.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `c`=0, counter 0.
- **Accept** occurs on an edge with `in_valid && in_ready`. `op`, `a` and `b` are latched on that edge; inputs are ignored at all other times.
- **MUL** produces the low 64 bits of a*b. Each BUSY cycle examines one multiplier bit (LSB first) and conditionally adds the shifted multiplicand.
- **DIV/REM (signed)** work on absolute values and record the quotient and remainder signs at accept.
  - Each BUSY cycle performs one restoring step: shift the remainder left with the next dividend bit, trial subtract, keep the result if nonnegative, and set the quotient bit.
  - Signs are applied on the transition into DONE. The quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- **DIVU/REMU** use the same datapath with no sign fixup.
- **Special cases** are detected at accept and go to DONE on the next edge without entering BUSY:
  - Divide by zero: quotient = all ones; remainder = `a`.
  - Signed overflow (`a`=0x8000_0000_0000_0000, `b`=all ones): quotient = `a`; remainder = 0.
- **Unsupported op codes** go directly to DONE with `c`=0.
- BUSY runs exactly 64 iterations, with a 6-bit counter counting down from 63; the transition to DONE happens when the counter reaches 0.
- In DONE, `out_valid`=1 and `c` is held stable until an edge with `out_ready`=1, which returns the state to IDLE.
- `flush` in BUSY or DONE returns the state to IDLE on the next edge. `out_valid` drops and the result is discarded.
  - `flush` has priority over `out_ready`.
  - In IDLE, `flush` blocks acceptance on that edge.
- Reset asserted mid-operation forces IDLE immediately (asynchronously). No result is produced.

## Timing
- Normal op: accept at edge E0, BUSY during E1..E64, `out_valid` high from the cycle after E64. Latency is 65 cycles from accept to `out_valid`.
- Special cases and unsupported ops: `out_valid` is high the cycle after E0 (latency 1).
- Back-to-back throughput: the earliest next accept is the edge after the result handshake. `in_ready` rises the cycle after `out_valid && out_ready` is sampled; there is no same-cycle bypass.
- `in_ready` and `out_valid` are registered state decodes and never combinationally depend on `in_valid` or `out_ready`.

## Configuration
- `MULDIV_WORD_EN` defined: op codes 8–12 are supported.
  - Operands use `a[31:0]`/`b[31:0]`, sign-extended for MULW/DIVW/REMW and zero-extended for DIVUW/REMUW.
  - The 64-step datapath and latency are unchanged.
  - `c` = sign-extension of result bits [31:0].
  - Word special cases: divide by zero gives quotient all ones and remainder sign-extended `a[31:0]`. Overflow is `a[31:0]`=0x8000_0000 with `b[31:0]`=0xFFFF_FFFF, giving quotient 0xFFFF_FFFF_8000_0000 and remainder 0.
- `MULDIV_WORD_EN` undefined: codes 8–12 are unsupported (`c`=0, latency 1). No word-mode logic is synthesized.

## Test plan
- MUL: `a`=7, `b`=0xFFFF_FFFF_FFFF_FFFD. Expect `c`=0xFFFF_FFFF_FFFF_FFEB after 65 cycles; `in_ready` is low throughout.
- DIV and REM, `a`=-7, `b`=2: DIV gives `c`=-3 (0xFFFF_FFFF_FFFF_FFFD); REM gives `c`=-1. DIVU with `a`=100, `b`=7 gives `c`=14; REMU gives 2.
- Special cases:
  - DIVU `a`=5, `b`=0 → `c`=all ones at latency 1; REM `a`=5, `b`=0 → 5.
  - DIV `a`=0x8000_0000_0000_0000, `b`=-1 → `c`=0x8000_0000_0000_0000; REM → 0.
- Hold `out_ready`=0 for 10 cycles after `out_valid`. `c` must stay constant and `in_valid` must not be accepted. Release `out_ready`, then check `in_ready`=1 on the next cycle.
- Flush and reset:
  - Assert `flush` at BUSY iteration 30 → IDLE next edge with `out_valid` never high. A new MUL 3*4 then returns 12.
  - Assert `reset` mid-BUSY → all outputs at reset values immediately.
- With `MULDIV_WORD_EN`:
  - DIVW `a`=0x1_FFFF_FFF9, `b`=2 → 0xFFFF_FFFF_FFFF_FFFD.
  - MULW `a`=0x10000, `b`=0x10000 → 0.
- Without `MULDIV_WORD_EN`: the same ops return 0 at latency 1.
